// File: rtl/mpu_fetch_if.sv
// mpu_fetch_if: bus bundle between the MPU fetch front end and its neighbours.
//   r_addr/r_data      : combinational 48-bit read window into mpu_memory
//   i_valid/i_ready/i_*: decoded instruction handshake towards execute
//   jmp_en/jmp_addr    : PC redirect coming back from execute
// Modports: master = fetch side, slave = memory/execute side.
interface mpu_fetch_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] r_addr;
    logic [47:0]       r_data;
    logic              i_valid;
    logic              i_ready;
    logic [3:0]        i_op;
    logic [1:0]        i_size;
    logic [4:0]        i_r0;
    logic [4:0]        i_r1;
    logic [4:0]        i_r2;
    logic [4:0]        i_r3;
    logic [31:0]       i_imm;
    logic [2:0]        i_len;
    logic [ADDR_W-1:0] i_pc;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;

    modport master (
        output r_addr, i_valid, i_op, i_size, i_r0, i_r1, i_r2, i_r3, i_imm, i_len, i_pc,
        input  r_data, i_ready, jmp_en, jmp_addr
    );
    modport slave (
        input  r_addr, i_valid, i_op, i_size, i_r0, i_r1, i_r2, i_r3, i_imm, i_len, i_pc,
        output r_data, i_ready, jmp_en, jmp_addr
    );
endinterface

// File: rtl/mpu_fetch.sv
// mpu_fetch: MPU instruction fetch/decode front end.
// Drives the memory read address from an internal PC, decodes one 2..6 byte
// instruction per slot and offers it to execute over a valid/ready handshake.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start, stop        : begin fetching from RESET_PC / return to idle
//   bus (master)       : read window, instruction handshake, jump redirect
//   err                : sticky illegal-instruction flag (cleared by start)
//   icount             : accepted-instruction counter
// Optional feature: define MPU_FETCH_ICOUNT_EN to build the icount counter;
// otherwise icount is tied to zero.
`ifndef MPU_OP_LOAD
`define MPU_OP_LOAD 4'h1
`endif
`ifndef MPU_OP_MASK
`define MPU_OP_MASK 4'h2
`endif
`ifndef MPU_OP_JMP
`define MPU_OP_JMP 4'h3
`endif

module mpu_fetch #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    mpu_fetch_if.master bus,
    output logic        err,
    output logic [31:0] icount
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_e;

    typedef struct packed {
        logic [3:0]        op;
        logic [1:0]        size;
        logic [4:0]        r0;
        logic [4:0]        r1;
        logic [4:0]        r2;
        logic [4:0]        r3;
        logic [31:0]       imm;
        logic [2:0]        len;
        logic [ADDR_W-1:0] pc;
    } instr_t;

    state_e          state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t          ins_q, ins_d, dec;
    logic            vld_q, vld_d;
    logic            err_q, err_d;
    logic            legal;
    logic [ADDR_W:0] end_addr;   // PC+len with carry: one past the last byte
    logic            start_go;
    logic            accept;

    // Combinational decode of the window at PC.
    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        dec.op   = bus.r_data[7:4];
        dec.size = bus.r_data[1:0];
        dec.pc   = pc_q;
        case (bus.r_data[7:4])
            `MPU_OP_LOAD: begin
                dec.r0 = bus.r_data[15:11];
                legal  = 1'b1;
                case (bus.r_data[1:0])
                    2'd0: begin dec.len = 3'd3; dec.imm = {24'd0, bus.r_data[23:16]}; end
                    2'd1: begin dec.len = 3'd4; dec.imm = {16'd0, bus.r_data[31:16]}; end
                    2'd2: begin dec.len = 3'd6; dec.imm = bus.r_data[47:16]; end
                    default: legal = 1'b0;
                endcase
            end
            `MPU_OP_MASK: begin
                dec.len = 3'd5;
                dec.r0  = bus.r_data[15:11];
                dec.r1  = bus.r_data[23:19];
                dec.r2  = bus.r_data[31:27];
                dec.r3  = bus.r_data[39:35];
                legal   = 1'b1;
            end
            `MPU_OP_JMP: begin
                dec.len = 3'd2;
                dec.r0  = bus.r_data[15:11];
                legal   = 1'b1;
            end
            default: ;
        endcase
        // An instruction may end exactly at the top of the address space
        // (end_addr == 2^ADDR_W) but must not run past it.
        end_addr = {1'b0, pc_q} + {{(ADDR_W-2){1'b0}}, dec.len};
        if (end_addr[ADDR_W] && (|end_addr[ADDR_W-1:0]))
            legal = 1'b0;
    end

    assign start_go = start && !stop && (state_q == IDLE || state_q == HALT);
    assign accept   = vld_q && bus.i_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        vld_d   = vld_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (start_go) begin
                    pc_d    = RESET_PC;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!legal) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            ISSUE: begin
                if (accept && !legal) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            HALT: begin
                vld_d = 1'b0;
                if (start_go) begin
                    pc_d    = RESET_PC;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Load a decoded instruction from FETCH, or back-to-back on accept.
        if (legal && (state_q == FETCH || (state_q == ISSUE && accept))) begin
            ins_d   = dec;
            pc_d    = end_addr[ADDR_W-1:0];
            vld_d   = 1'b1;
            state_d = ISSUE;
        end

        // Redirect beats everything, including stop and a same-cycle load.
        if (state_q != IDLE && bus.jmp_en) begin
            pc_d    = bus.jmp_addr;
            ins_d   = ins_q;
            vld_d   = 1'b0;
            err_d   = (state_q == HALT) ? 1'b0 : err_q;
            state_d = FETCH;
        end else if (stop && (state_q == FETCH || state_q == ISSUE)) begin
            pc_d    = pc_q;
            ins_d   = ins_q;
            vld_d   = 1'b0;
            err_d   = err_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

`ifdef MPU_FETCH_ICOUNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    cnt_q <= '0;
        else if (start_go) cnt_q <= '0;
        else if (accept)   cnt_q <= cnt_q + 32'd1;
    end
    assign icount = cnt_q;
`else
    assign icount = '0;
`endif

    assign err         = err_q;
    assign bus.r_addr  = pc_q;
    assign bus.i_valid = vld_q;
    assign bus.i_op    = ins_q.op;
    assign bus.i_size  = ins_q.size;
    assign bus.i_r0    = ins_q.r0;
    assign bus.i_r1    = ins_q.r1;
    assign bus.i_r2    = ins_q.r2;
    assign bus.i_r3    = ins_q.r3;
    assign bus.i_imm   = ins_q.imm;
    assign bus.i_len   = ins_q.len;
    assign bus.i_pc    = ins_q.pc;
endmodule

// File: tb/tb_mpu_fetch.sv
`ifndef MPU_OP_LOAD
`define MPU_OP_LOAD 4'h1
`endif
`ifndef MPU_OP_MASK
`define MPU_OP_MASK 4'h2
`endif
`ifndef MPU_OP_JMP
`define MPU_OP_JMP 4'h3
`endif

module tb_mpu_fetch;
    localparam logic [3:0] OP_LOAD = `MPU_OP_LOAD;
    localparam logic [3:0] OP_MASK = `MPU_OP_MASK;
    localparam logic [3:0] OP_JMP  = `MPU_OP_JMP;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        err;
    logic [31:0] icount;

    mpu_fetch_if #(.ADDR_W(16)) bus ();

    mpu_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .bus(bus), .err(err), .icount(icount)
    );

    always #5 sys_clk = ~sys_clk;

    // Byte memory behind the combinational read window.
    logic [7:0]  mem [65536];
    logic [47:0] rd;
    always_comb begin
        rd = '0;
        for (int k = 0; k < 6; k++) rd[8*k +: 8] = mem[16'(bus.r_addr + 16'(k))];
    end
    assign bus.r_data = rd;

    int n_vec = 0, n_err = 0, acc_cnt = 0;

    typedef struct { bit legal; logic [60:0] f; logic [2:0] len; } mdl_t;
    typedef struct { logic [15:0] addr; logic [47:0] bytes; bit legal; logic [60:0] f; } vec_t;

    function automatic logic [60:0] pk(logic [3:0] op, logic [1:0] sz, logic [4:0] a, logic [4:0] b,
                                       logic [4:0] c, logic [4:0] d, logic [31:0] imm, logic [2:0] len);
        return {op, sz, a, b, c, d, imm, len};
    endfunction

    function automatic logic [60:0] dut_f();
        return {bus.i_op, bus.i_size, bus.i_r0, bus.i_r1, bus.i_r2, bus.i_r3, bus.i_imm, bus.i_len};
    endfunction

    // Reference decoder: length/legality from the instruction rules, immediate
    // assembled arithmetically from little-endian bytes.
    function automatic mdl_t model(logic [15:0] a);
        mdl_t m;
        logic [7:0]  b [6];
        logic [4:0]  r [4];
        logic [31:0] imm;
        int n, len;
        for (int k = 0; k < 6; k++) b[k] = mem[16'(a + 16'(k))];
        for (int k = 0; k < 4; k++) r[k] = '0;
        len = 0; imm = 0;
        if (b[0][7:4] == OP_LOAD && b[0][1:0] != 2'd3) begin
            n = 1 << b[0][1:0];
            len = 2 + n;
            r[0] = b[1][7:3];
            for (int k = 0; k < n; k++) imm = imm + (32'(b[2+k]) << (8*k));
        end else if (b[0][7:4] == OP_MASK) begin
            len = 5;
            for (int k = 0; k < 4; k++) r[k] = b[k+1][7:3];
        end else if (b[0][7:4] == OP_JMP) begin
            len = 2;
            r[0] = b[1][7:3];
        end
        m.legal = (len != 0) && (int'(a) + len <= 65536);
        m.len   = 3'(len);
        m.f     = pk(b[0][7:4], b[0][1:0], r[0], r[1], r[2], r[3], imm, 3'(len));
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ic();
`ifdef MPU_FETCH_ICOUNT_EN
        return 32'(acc_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        if (bus.i_valid === 1'b1 && bus.i_ready === 1'b1) acc_cnt++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; acc_cnt = 0;
        step();
        start = 1'b0;
    endtask

    task automatic jump(input logic [15:0] a);
        bus.jmp_en = 1'b1; bus.jmp_addr = a;
        step();
        bus.jmp_en = 1'b0;
    endtask

    task automatic put(input logic [15:0] a, input logic [47:0] bytes);
        for (int k = 0; k < 6; k++) mem[16'(a + 16'(k))] = bytes[8*k +: 8];
    endtask

    vec_t        tbl [10];
    logic [15:0] starts [$];
    logic [15:0] exp_pc, end_addr, a;
    mdl_t        m;
    logic        rdy, jmp, done;
    int          njmp, t;

    initial begin
        tbl[0] = '{16'h0400, 48'h3322_11AB_2810, 1'b1, pk(OP_LOAD, 2'd0, 5'd5, 5'd0, 5'd0, 5'd0, 32'hAB, 3'd3)};
        tbl[1] = '{16'h0410, 48'h7799_1234_F81D, 1'b1, pk(OP_LOAD, 2'd1, 5'd31, 5'd0, 5'd0, 5'd0, 32'h1234, 3'd4)};
        tbl[2] = '{16'h0420, 48'h1234_5678_0812, 1'b1, pk(OP_LOAD, 2'd2, 5'd1, 5'd0, 5'd0, 5'd0, 32'h12345678, 3'd6)};
        tbl[3] = '{16'h0430, 48'hFFFF_FFFF_0813, 1'b0, '0};
        tbl[4] = '{16'h0440, 48'hFF20_1810_0820, 1'b1, pk(OP_MASK, 2'd0, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0, 3'd5)};
        tbl[5] = '{16'h0450, 48'hFFFF_FFFF_5033, 1'b1, pk(OP_JMP, 2'd3, 5'd10, 5'd0, 5'd0, 5'd0, 32'h0, 3'd2)};
        tbl[6] = '{16'h0460, 48'h0000_0000_FF00, 1'b0, '0};
        tbl[7] = '{16'h0470, 48'h1111_1111_11F4, 1'b0, '0};
        tbl[8] = '{16'hFFFE, 48'h0000_0000_1830, 1'b1, pk(OP_JMP, 2'd0, 5'd3, 5'd0, 5'd0, 5'd0, 32'h0, 3'd2)};
        tbl[9] = '{16'hFFFC, 48'h0020_1810_0820, 1'b0, '0};

        bus.i_ready = 1'b0; bus.jmp_en = 1'b0; bus.jmp_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hF0;
        // LOAD r0 #ff | LOAD r0 #00ff | MASK r1..r4 | JMP r4 | illegal
        put(16'd0, 48'h0000_00FF_0010);
        put(16'd3, 48'h0000_00FF_0011);
        put(16'd7, 48'h0020_1810_0820);
        mem[12] = 8'h30; mem[13] = 8'h20;

        #12;
        chk("rst_valid", bus.i_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_icount", icount, 0);
        chk("rst_raddr", bus.r_addr, 0);
        chk("rst_fields", dut_f(), 0);
        chk("rst_ipc", bus.i_pc, 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        step();

        // Start latency and back-to-back issue.
        do_start();
        chk("start_lat1", bus.i_valid, 0);
        step();
        chk("start_lat2", bus.i_valid, 1);
        chk("first_fields", dut_f(), pk(OP_LOAD, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFF, 3'd3));
        chk("first_pc", bus.i_pc, 0);
        bus.i_ready = 1'b1;
        step();
        chk("b2b_pc3", bus.i_pc, 3);
        chk("b2b_imm", bus.i_imm, 32'hFF);
        step();
        chk("b2b_pc7", bus.i_pc, 7);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", bus.i_valid, 1);
            chk("stall_fields", {bus.i_pc, dut_f()}, {16'd7, pk(OP_MASK, 2'd0, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0, 3'd5)});
            chk("stall_raddr", bus.r_addr, 12);
        end
        bus.i_ready = 1'b1;
        step();
        chk("jmp_instr", {bus.i_pc, dut_f()}, {16'd12, pk(OP_JMP, 2'd0, 5'd4, 5'd0, 5'd0, 5'd0, 32'h0, 3'd2)});
        // Redirect while accepting the JMP.
        jump(16'd0);
        bus.i_ready = 1'b0;
        chk("redir_lat1", bus.i_valid, 0);
        chk("redir_icount", icount, exp_ic());
        step();
        chk("redir_lat2", {bus.i_valid, bus.i_pc}, {1'b1, 16'd0});
        bus.i_ready = 1'b1;
        step(); step(); step(); step();
        chk("illegal_valid", bus.i_valid, 0);
        chk("illegal_err", err, 1);
        bus.i_ready = 1'b0;
        step(); step(); step();
        chk("halt_frozen", {bus.i_valid, err, bus.r_addr}, {1'b1 ^ 1'b1, 1'b1, 16'd14});
        chk("halt_icount", icount, exp_ic());
        do_start();
        chk("start_clr_err", {err, bus.i_valid}, 0);
        chk("start_clr_icount", icount, 0);
        step();
        chk("restart_valid", {bus.i_valid, bus.i_pc}, {1'b1, 16'd0});

        // stop, ignored jump in IDLE, start+stop, jump+stop, start while busy.
        bus.i_ready = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0; bus.i_ready = 1'b0;
        chk("stop_drop", bus.i_valid, 0);
        step();
        jump(16'd3);
        step();
        chk("idle_jmp_ignored", bus.i_valid, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        chk("start_stop", bus.i_valid, 0);
        do_start();
        step();
        chk("start_again", {bus.i_valid, bus.i_pc}, {1'b1, 16'd0});
        stop = 1'b1;
        jump(16'd7);
        stop = 1'b0;
        chk("jmp_stop_lat1", bus.i_valid, 0);
        step();
        chk("jmp_beats_stop", {bus.i_valid, bus.i_pc}, {1'b1, 16'd7});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {bus.i_valid, bus.i_pc}, {1'b1, 16'd7});
        chk("busy_icount", icount, exp_ic());

        // Top-of-memory boundary.
        put(16'hFFFA, 48'h1234_5678_0012);
        jump(16'hFFFA);
        step();
        chk("top_legal", {bus.i_valid, bus.i_pc, bus.i_imm}, {1'b1, 16'hFFFA, 32'h12345678});
        chk("top_wrap_raddr", bus.r_addr, 0);
        mem[16'hFFFC] = 8'h12;
        jump(16'hFFFC);
        step();
        chk("top_overrun", {bus.i_valid, err}, {1'b0, 1'b1});

        // Decode table.
        for (int v = 0; v < 10; v++) begin
            put(tbl[v].addr, tbl[v].bytes);
            jump(tbl[v].addr);
            chk("tbl_lat1", bus.i_valid, 0);
            step();
            chk($sformatf("tbl%0d_status", v), {bus.i_valid, err}, {tbl[v].legal, !tbl[v].legal});
            if (tbl[v].legal)
                chk($sformatf("tbl%0d_fields", v), {bus.i_pc, dut_f()}, {tbl[v].addr, tbl[v].f});
        end

        // Random programs, random ready and redirects, against the model.
        for (int r = 0; r < 3; r++) begin
            starts.delete();
            for (int i = 0; i < 300; i++) mem[16'h1000 + i] = 8'($urandom);
            a = 16'h1000;
            for (int i = 0; i < int'($urandom_range(15, 30)); i++) begin
                starts.push_back(a);
                t = int'($urandom_range(0, 4));
                if (t < 3)       mem[a] = {OP_LOAD, 2'($urandom), 2'(t)};
                else if (t == 3) mem[a] = {OP_MASK, 4'($urandom)};
                else             mem[a] = {OP_JMP, 4'($urandom)};
                a = a + ((t < 3) ? 16'(2 + (1 << t)) : (t == 3) ? 16'd5 : 16'd2);
            end
            mem[a] = 8'hF0;
            end_addr = a;
            bus.i_ready = 1'b0;
            exp_pc = 16'h1000;
            jump(16'h1000);
            chk("rnd_jmp_clr", {bus.i_valid, err}, 0);
            done = 1'b0; njmp = 0;
            for (int c = 0; c < 2000 && !done; c++) begin
                if (err) begin
                    chk("rnd_halt_addr", bus.r_addr, end_addr);
                    chk("rnd_halt_valid", bus.i_valid, 0);
                    chk("rnd_icount", icount, exp_ic());
                    done = 1'b1;
                end else begin
                    m = model(exp_pc);
                    if (bus.i_valid) begin
                        chk("rnd_pc", bus.i_pc, exp_pc);
                        chk("rnd_fields", dut_f(), m.f);
                    end
                    rdy = ($urandom_range(0, 9) < 7);
                    jmp = (njmp < 4) && ($urandom_range(0, 29) == 0);
                    if (bus.i_valid && rdy) exp_pc = exp_pc + 16'(m.len);
                    if (jmp) begin
                        exp_pc = starts[$urandom_range(0, starts.size() - 1)];
                        njmp++;
                    end
                    bus.i_ready = rdy; bus.jmp_en = jmp; bus.jmp_addr = exp_pc;
                    step();
                    bus.jmp_en = 1'b0;
                    if (jmp) chk("rnd_jmp_drop", bus.i_valid, 0);
                end
            end
            if (!done) chk("rnd_timeout", 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
